// File: rtl/key_pulse_pkg.sv
// Shared types and sizing helper for the key_pulse debouncer.
package key_pulse_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

  // Counter must hold the largest threshold it is ever compared against.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer; both flops reset to RESET_VAL.
module key_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/key_pulse.sv
// Push-button debouncer: one registered pulse per debounced press plus a held level.
// Auto-repeat while held is built only when KEY_PULSE_REPEAT_EN is defined.
//
// state        | meaning
// IDLE         | released, waiting for a press sample
// PRESS_WAIT   | counting consecutive press samples
// HELD         | debounced pressed (auto-repeat timing runs here if enabled)
// RELEASE_WAIT | counting consecutive release samples, still reported held
module key_pulse
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic pulse,
  output logic held
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_TH   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef KEY_PULSE_REPEAT_EN
  localparam logic [CW-1:0] DLY_TH  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_TH  = CW'(REPEAT_PERIOD - 1);
`endif

  logic          key_s;
  logic          pressed;
  key_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;
  logic          held_q;
`ifdef KEY_PULSE_REPEAT_EN
  logic          rep_phase_q;
`endif

  key_sync #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk_i  (clk),
    .reset_i(reset),
    .d_i    (key_raw),
    .q_o    (key_s)
  );

  assign pressed = key_s ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      held_q      <= 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
      rep_phase_q <= 1'b0;
`endif
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= IDLE;
          end else if (cnt_q == DB_TH) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
            held_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q     <= RELEASE_WAIT;
            cnt_q       <= CNT_ONE;
`ifdef KEY_PULSE_REPEAT_EN
            rep_phase_q <= 1'b0;
          end else if (cnt_q == (rep_phase_q ? PER_TH : DLY_TH)) begin
            pulse_q     <= 1'b1;
            cnt_q       <= '0;
            rep_phase_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
`endif
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed re-enters HELD silently; repeat timing restarts.
          if (pressed) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_TH) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: tb/tb_key_pulse.sv
// Self-checking bench for key_pulse against a run-length reference model.
module tb_key_pulse;

  localparam int D   = 4;
  localparam bit AL  = 1'b1;
  localparam int DLY = 16;
  localparam int PER = 4;
  localparam logic REL = AL;
  localparam logic PRS = ~AL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_raw = REL;
  logic pulse;
  logic held;

  int n_checks = 0;
  int n_errors = 0;

  key_pulse #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (AL),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_raw(key_raw),
    .pulse  (pulse),
    .held   (held)
  );

  always #5 clk = ~clk;

  // Reference model: a level becomes debounced after D+1 consecutive agreeing
  // samples of the two-edge-delayed key; repeats fire at DLY, DLY+PER, ... edges
  // after (re)entering the continuously-pressed held condition.
  logic d1 = REL, d2 = REL;
  logic deb = 1'b0;
  int   run = 0, rel = 0, r = 0;
  logic exp_pulse = 1'b0, exp_held = 1'b0;
  logic ps;

  always @(posedge clk) begin
    if (reset) begin
      d1 = REL; d2 = REL; deb = 1'b0; run = 0; rel = 0; r = 0;
      exp_pulse = 1'b0; exp_held = 1'b0;
    end else begin
      ps = (d2 == PRS);
      d2 = d1;
      d1 = key_raw;
      exp_pulse = 1'b0;
      if (!deb) begin
        if (ps) begin
          run++;
          if (run == D + 1) begin
            deb = 1'b1; run = 0; rel = 0; r = 0; exp_pulse = 1'b1;
          end
        end else run = 0;
      end else begin
        if (!ps) begin
          rel++;
          if (rel == D + 1) begin
            deb = 1'b0; rel = 0; run = 0;
          end
        end else if (rel > 0) begin
          rel = 0; r = 0;
        end else begin
          r++;
`ifdef KEY_PULSE_REPEAT_EN
          if (r >= DLY && ((r - DLY) % PER) == 0) exp_pulse = 1'b1;
`endif
        end
      end
      exp_held = deb;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    key_raw = REL;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pulse !== 1'b0 || held !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: pulse=%b held=%b, required 0 0", pulse, held);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (pulse !== 1'b0 || held !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_released cyc%0d: pulse=%b held=%b, required 0 0", i, pulse, held);
      end
    end
  endtask

  task automatic test_press_release();
    int first_pulse = -1, held_rise = -1, held_fall = -1, npulse = 0, exp_n;
`ifdef KEY_PULSE_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    key_raw = PRS;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL press_model k+%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
      if (pulse === 1'b1) begin
        npulse++;
        if (first_pulse < 0) first_pulse = j;
      end
      if (held === 1'b1 && held_rise < 0) held_rise = j;
    end
    key_raw = REL;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL release_model r+%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
      if (pulse === 1'b1) npulse++;
      if (held === 1'b0 && held_fall < 0) held_fall = j;
    end
    n_checks++;
    if (first_pulse !== D + 2) begin
      n_errors++;
      $display("FAIL press_latency: pulse after edge k+%0d, required k+%0d", first_pulse, D + 2);
    end
    n_checks++;
    if (held_rise !== D + 2) begin
      n_errors++;
      $display("FAIL held_rise: after edge k+%0d, required k+%0d", held_rise, D + 2);
    end
    n_checks++;
    if (held_fall !== D + 2) begin
      n_errors++;
      $display("FAIL held_fall: after edge r+%0d, required r+%0d", held_fall, D + 2);
    end
    n_checks++;
    if (npulse !== exp_n) begin
      n_errors++;
      $display("FAIL press_pulse_count: got %0d, required %0d", npulse, exp_n);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    for (int j = 0; j < 15; j++) begin
      key_raw = (j < 3) ? PRS : REL;
      @(negedge clk);
      if (pulse !== 1'b0 || held !== 1'b0) bad++;
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL glitch_model cyc%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL glitch_rejected: %0d cycles with pulse/held set, required 0", bad);
    end
  endtask

  task automatic test_bounce();
    int npulse = 0, held_drop = 0;
    for (int j = 0; j < 22; j++) begin
      key_raw = (j == 10 || j == 11) ? REL : PRS;
      @(negedge clk);
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL bounce_model k+%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
      if (pulse === 1'b1) npulse++;
      if (j >= D + 2 && held !== 1'b1) held_drop++;
    end
    n_checks++;
    if (npulse !== 1) begin
      n_errors++;
      $display("FAIL bounce_pulses: got %0d, required 1", npulse);
    end
    n_checks++;
    if (held_drop !== 0) begin
      n_errors++;
      $display("FAIL bounce_held: held low in %0d cycles, required 0", held_drop);
    end
    key_raw = REL;
    repeat (12) @(negedge clk);
    n_checks++;
    if (held !== 1'b0) begin
      n_errors++;
      $display("FAIL bounce_final_release: held=%b, required 0", held);
    end
  endtask

  task automatic test_repeat();
    int got[$];
    int want[$];
`ifdef KEY_PULSE_REPEAT_EN
    want = '{6, 22, 26, 30, 34, 38};
`else
    want = '{6};
`endif
    key_raw = PRS;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL repeat_model k+%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
      if (pulse === 1'b1) got.push_back(j);
    end
    key_raw = REL;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (pulse === 1'b1) got.push_back(40 + j);
    end
    n_checks++;
    if (got.size() != want.size()) begin
      n_errors++;
      $display("FAIL repeat_count: got %0d pulses, required %0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        n_checks++;
        if (got[i] != want[i]) begin
          n_errors++;
          $display("FAIL repeat_edge%0d: after k+%0d, required k+%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int new_pulse = -1;
    key_raw = PRS;
    for (int j = 0; j < 24; j++) begin
      reset = (j == 10);
      @(negedge clk);
      if (j == 10) begin
        n_checks++;
        if (pulse !== 1'b0 || held !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_mid_clear: pulse=%b held=%b, required 0 0", pulse, held);
        end
      end
      n_checks++;
      if (pulse !== exp_pulse || held !== exp_held) begin
        n_errors++;
        $display("FAIL reset_mid_model k+%0d: pulse=%b held=%b, required %b %b", j, pulse, held, exp_pulse, exp_held);
      end
      if (j > 10 && pulse === 1'b1 && new_pulse < 0) new_pulse = j;
    end
    reset = 1'b0;
    n_checks++;
    if (new_pulse !== 11 + D + 2) begin
      n_errors++;
      $display("FAIL reset_mid_repress: pulse after edge k+%0d, required k+%0d", new_pulse, 11 + D + 2);
    end
    key_raw = REL;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 80; n++) begin
      key_raw = $urandom_range(1, 0) ? PRS : REL;
      len = $urandom_range(12, 1);
      for (int j = 0; j < len; j++) begin
        reset = ($urandom_range(59, 0) == 0);
        @(negedge clk);
        n_checks++;
        if (pulse !== exp_pulse || held !== exp_held) begin
          n_errors++;
          $display("FAIL random_model run%0d cyc%0d: pulse=%b held=%b, required %b %b", n, j, pulse, held, exp_pulse, exp_held);
        end
      end
    end
    reset = 1'b0;
    key_raw = REL;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_bounce();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
